// File: rtl/hex_syscall_unit.sv
// hex_syscall_unit: services OPR/SVC supervisor calls from the hex processor.
// One request is outstanding at a time. WRITE sends a byte on the TX channel,
// READ fetches a byte from the RX channel (with optional EOF timeout), and an
// illegal code sets a sticky error flag. Each of these returns one response word.
// EXIT latches its operand and parks the unit until reset.
module hex_syscall_unit #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STREAM_WIDTH = 8,
   parameter int unsigned RX_TIMEOUT   = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [1:0]              i_req_call,
   input  logic [STREAM_WIDTH-1:0] i_req_stream,
   input  logic [DATA_WIDTH-1:0]   i_req_data,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_data,
   output logic                    o_tx_valid,
   input  logic                    i_tx_ready,
   output logic [7:0]              o_tx_data,
   output logic [STREAM_WIDTH-1:0] o_tx_stream,
   input  logic                    i_rx_valid,
   output logic                    o_rx_ready,
   input  logic [7:0]              i_rx_data,
   output logic [STREAM_WIDTH-1:0] o_rx_stream,
   output logic                    o_exit,
   output logic [DATA_WIDTH-1:0]   o_exit_code,
   output logic                    o_error
);

   // Counter only needs to reach RX_TIMEOUT-1; keep at least one bit so the
   // RX_TIMEOUT=0 (wait forever) build still elaborates cleanly.
   localparam int CNT_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST =
      CNT_W'((RX_TIMEOUT > 0) ? (RX_TIMEOUT - 1) : 0);

   typedef enum logic [2:0] {
      IDLE,
      TX,
      RX,
      RSP,
      HALT
   } state_t;

   state_t                  state_q,     state_d;
   logic [STREAM_WIDTH-1:0] stream_q,    stream_d;
   logic [DATA_WIDTH-1:0]   data_q,      data_d;
   logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
   logic                    exit_q,      exit_d;
   logic [DATA_WIDTH-1:0]   exit_code_q, exit_code_d;
   logic                    error_q,     error_d;
   logic [CNT_W-1:0]        rx_cnt_q,    rx_cnt_d;

   // Next-state logic: request decode, channel handshakes, RX timeout and response hand-off.
   always_comb begin
      state_d     = state_q;
      stream_d    = stream_q;
      data_d      = data_q;
      rsp_data_d  = rsp_data_q;
      exit_d      = exit_q;
      exit_code_d = exit_code_q;
      error_d     = error_q;
      rx_cnt_d    = rx_cnt_q;

      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               stream_d = i_req_stream;
               data_d   = i_req_data;
               rx_cnt_d = '0;
               case (i_req_call)
                  2'd0: begin
                     state_d     = HALT;
                     exit_d      = 1'b1;
                     exit_code_d = i_req_data;
                  end
                  2'd1:    state_d = TX;
                  2'd2:    state_d = RX;
                  default: begin
                     state_d    = RSP;
                     rsp_data_d = '0;
                     error_d    = 1'b1;
                  end
               endcase
            end
         end
         TX: begin
            if (i_tx_ready) begin
               state_d    = RSP;
               rsp_data_d = '0;
            end
         end
         RX: begin
            if (i_rx_valid) begin
               state_d    = RSP;
               rsp_data_d = DATA_WIDTH'(i_rx_data);
            end else if ((RX_TIMEOUT > 0) && (rx_cnt_q == TIMEOUT_LAST)) begin
               state_d    = RSP;
               rsp_data_d = '1;
            end else if (RX_TIMEOUT > 0) begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RSP: begin
            if (i_rsp_ready) begin
               state_d = IDLE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight request silently.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         stream_q    <= '0;
         data_q      <= '0;
         rsp_data_q  <= '0;
         exit_q      <= 1'b0;
         exit_code_q <= '0;
         error_q     <= 1'b0;
         rx_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         stream_q    <= stream_d;
         data_q      <= data_d;
         rsp_data_q  <= rsp_data_d;
         exit_q      <= exit_d;
         exit_code_q <= exit_code_d;
         error_q     <= error_d;
         rx_cnt_q    <= rx_cnt_d;
      end
   end

   // Outputs decode from the registered state; ready is also masked by reset
   // so the processor never sees an accept while the unit is held in reset.
   always_comb begin
      o_req_ready = (state_q == IDLE) && i_rst_n;
      o_tx_valid  = (state_q == TX);
      o_tx_data   = (state_q == TX) ? data_q[7:0] : 8'h00;
      o_tx_stream = (state_q == TX) ? stream_q : '0;
      o_rx_ready  = (state_q == RX);
      o_rx_stream = (state_q == RX) ? stream_q : '0;
      o_rsp_valid = (state_q == RSP);
      o_rsp_data  = rsp_data_q;
      o_exit      = exit_q;
      o_exit_code = exit_code_q;
      o_error     = error_q;
   end

endmodule

// File: tb/tb_hex_syscall_unit.sv
// Directed bench for hex_syscall_unit (RX_TIMEOUT=16) with a transaction-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_hex_syscall_unit;

   localparam int DW  = 32;
   localparam int SW  = 8;
   localparam int TMO = 16;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_req_valid = 1'b0;
   logic          o_req_ready;
   logic [1:0]    i_req_call = 2'd0;
   logic [SW-1:0] i_req_stream = '0;
   logic [DW-1:0] i_req_data = '0;
   logic          o_rsp_valid;
   logic          i_rsp_ready = 1'b0;
   logic [DW-1:0] o_rsp_data;
   logic          o_tx_valid;
   logic          i_tx_ready = 1'b0;
   logic [7:0]    o_tx_data;
   logic [SW-1:0] o_tx_stream;
   logic          i_rx_valid = 1'b0;
   logic          o_rx_ready;
   logic [7:0]    i_rx_data = 8'h00;
   logic [SW-1:0] o_rx_stream;
   logic          o_exit;
   logic [DW-1:0] o_exit_code;
   logic          o_error;

   int vectors = 0;
   int miscompares = 0;
   int tx_hs_count = 0;

   hex_syscall_unit #(
      .DATA_WIDTH  (DW),
      .STREAM_WIDTH(SW),
      .RX_TIMEOUT  (TMO)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_call  (i_req_call),
      .i_req_stream(i_req_stream),
      .i_req_data  (i_req_data),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_data  (o_rsp_data),
      .o_tx_valid  (o_tx_valid),
      .i_tx_ready  (i_tx_ready),
      .o_tx_data   (o_tx_data),
      .o_tx_stream (o_tx_stream),
      .i_rx_valid  (i_rx_valid),
      .o_rx_ready  (o_rx_ready),
      .i_rx_data   (i_rx_data),
      .o_rx_stream (o_rx_stream),
      .o_exit      (o_exit),
      .o_exit_code (o_exit_code),
      .o_error     (o_error)
   );

   // Free-running clock.
   always #5 i_clk = ~i_clk;

   // Single comparison point: every check funnels through here.
   function automatic void check_output(input string name, input logic [31:0] act,
                                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model state: one outstanding transaction described by what it
   // still needs (host byte or processor accept), not by the DUT's encoding.
   bit          m_halted = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_err = 1'b0;
   bit          m_exit = 1'b0;
   logic [1:0]  m_call = 2'd0;
   logic [7:0]  m_stream = 8'h00;
   logic [7:0]  m_byte = 8'h00;
   logic [31:0] m_rsp = 32'h0;
   logic [31:0] m_exit_code = 32'h0;
   int          m_waited = 0;

   // Advance the model on the same edges as the DUT, from the sampled inputs.
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_halted    <= 1'b0;
         m_busy      <= 1'b0;
         m_done      <= 1'b0;
         m_err       <= 1'b0;
         m_exit      <= 1'b0;
         m_call      <= 2'd0;
         m_stream    <= 8'h00;
         m_byte      <= 8'h00;
         m_rsp       <= 32'h0;
         m_exit_code <= 32'h0;
         m_waited    <= 0;
      end else if (m_halted) begin
         m_busy <= 1'b0;
      end else if (!m_busy) begin
         if (i_req_valid) begin
            m_call   <= i_req_call;
            m_stream <= i_req_stream;
            m_byte   <= i_req_data[7:0];
            m_waited <= 0;
            if (i_req_call == 2'd0) begin
               m_halted    <= 1'b1;
               m_exit      <= 1'b1;
               m_exit_code <= i_req_data;
            end else if (i_req_call == 2'd3) begin
               m_busy <= 1'b1;
               m_done <= 1'b1;
               m_rsp  <= 32'h0;
               m_err  <= 1'b1;
            end else begin
               m_busy <= 1'b1;
               m_done <= 1'b0;
            end
         end
      end else if (!m_done) begin
         if (m_call == 2'd1) begin
            if (i_tx_ready) begin
               m_done <= 1'b1;
               m_rsp  <= 32'h0;
            end
         end else begin
            if (i_rx_valid) begin
               m_done <= 1'b1;
               m_rsp  <= {24'h0, i_rx_data};
            end else if (m_waited + 1 == TMO) begin
               m_done <= 1'b1;
               m_rsp  <= 32'hFFFF_FFFF;
            end else begin
               m_waited <= m_waited + 1;
            end
         end
      end else if (i_rsp_ready) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end
   end

   // Count host-side byte transfers so duplicate handshakes are visible.
   always @(posedge i_clk) begin
      if (i_rst_n && o_tx_valid && i_tx_ready) tx_hs_count <= tx_hs_count + 1;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge i_clk) begin : cmp
      logic e_tx;
      logic e_rx;
      e_tx = m_busy && (m_call == 2'd1) && !m_done;
      e_rx = m_busy && (m_call == 2'd2) && !m_done;
      check_output("req_ready", 32'(o_req_ready), 32'(i_rst_n && !m_halted && !m_busy));
      check_output("tx_valid", 32'(o_tx_valid), 32'(e_tx));
      check_output("tx_data", 32'(o_tx_data), e_tx ? 32'(m_byte) : 32'h0);
      check_output("tx_stream", 32'(o_tx_stream), e_tx ? 32'(m_stream) : 32'h0);
      check_output("rx_ready", 32'(o_rx_ready), 32'(e_rx));
      check_output("rx_stream", 32'(o_rx_stream), e_rx ? 32'(m_stream) : 32'h0);
      check_output("rsp_valid", 32'(o_rsp_valid), 32'(m_busy && m_done));
      check_output("rsp_data", o_rsp_data, m_rsp);
      check_output("exit", 32'(o_exit), 32'(m_exit));
      check_output("exit_code", o_exit_code, m_exit_code);
      check_output("error", 32'(o_error), 32'(m_err));
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Present a request and hold it until the unit accepts it (bounded).
   task automatic apply_stimulus(input logic [1:0] call, input logic [7:0] stream,
                                 input logic [31:0] data);
      bit accepted;
      accepted     = 1'b0;
      i_req_valid  = 1'b1;
      i_req_call   = call;
      i_req_stream = stream;
      i_req_data   = data;
      for (int n = 0; n < 20 && !accepted; n++) begin
         accepted = o_req_ready;
         tick();
      end
      i_req_valid = 1'b0;
      check_output("req_accepted", 32'(accepted), 32'd1);
   endtask

   // Wait (bounded) for a response, check its word, then accept it.
   task automatic take_rsp(input string name, input logic [31:0] exp);
      for (int n = 0; n < 40 && !o_rsp_valid; n++) tick();
      check_output({name, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
      check_output({name, "_rsp_data"}, o_rsp_data, exp);
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int hs_before;

      // Reset state
      repeat (2) tick();
      check_output("reset_req_ready", 32'(o_req_ready), 32'd0);
      check_output("reset_rsp_data", o_rsp_data, 32'h0);
      check_output("reset_exit", 32'(o_exit), 32'd0);
      i_rst_n = 1'b1;
      tick();
      check_output("post_reset_req_ready", 32'(o_req_ready), 32'd1);

      // Reset while a WRITE is stalled on the host
      i_tx_ready = 1'b0;
      apply_stimulus(2'd1, 8'd3, 32'h99);
      tick();
      check_output("stall_tx_valid", 32'(o_tx_valid), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      check_output("rst_tx_valid", 32'(o_tx_valid), 32'd0);
      check_output("rst_tx_data", 32'(o_tx_data), 32'h0);
      check_output("rst_tx_stream", 32'(o_tx_stream), 32'h0);
      check_output("rst_req_ready", 32'(o_req_ready), 32'd0);
      check_output("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      repeat (2) tick();
      i_rst_n = 1'b1;
      #1;
      check_output("release_req_ready", 32'(o_req_ready), 32'd1);
      tick();
      check_output("release_tx_valid", 32'(o_tx_valid), 32'd0);

      // WRITE stream 2 byte 0x41 with host stalled for 5 cycles
      hs_before = tx_hs_count;
      apply_stimulus(2'd1, 8'd2, 32'h41);
      for (int i = 0; i < 5; i++) begin
         check_output("stall5_tx_valid", 32'(o_tx_valid), 32'd1);
         check_output("stall5_tx_data", 32'(o_tx_data), 32'h41);
         check_output("stall5_tx_stream", 32'(o_tx_stream), 32'd2);
         tick();
      end
      i_tx_ready = 1'b1;
      tick();
      i_tx_ready = 1'b0;
      check_output("stall5_tx_done", 32'(o_tx_valid), 32'd0);
      check_output("stall5_hs_count", 32'(tx_hs_count - hs_before), 32'd1);
      take_rsp("write41", 32'h0);

      // WRITE latency with a ready host: tx at N+1, response at N+2
      i_tx_ready = 1'b1;
      apply_stimulus(2'd1, 8'd5, 32'hA5);
      check_output("lat_tx_valid", 32'(o_tx_valid), 32'd1);
      tick();
      i_tx_ready = 1'b0;
      check_output("lat_rsp_valid", 32'(o_rsp_valid), 32'd1);
      take_rsp("writeA5", 32'h0);

      // READ stream 0, byte arrives on the third RX cycle
      apply_stimulus(2'd2, 8'd0, 32'h0);
      check_output("read_rx_ready", 32'(o_rx_ready), 32'd1);
      repeat (2) tick();
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h5A;
      tick();
      i_rx_valid = 1'b0;
      take_rsp("read5A", 32'h0000_005A);

      // READ with processor stalling the response for 4 cycles
      apply_stimulus(2'd2, 8'd4, 32'h0);
      repeat (2) tick();
      i_rx_valid = 1'b1;
      i_rx_data  = 8'hC3;
      tick();
      i_rx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_output("hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
         check_output("hold_rsp_data", o_rsp_data, 32'h0000_00C3);
         tick();
      end
      take_rsp("readC3", 32'h0000_00C3);
      check_output("after_rsp_data", o_rsp_data, 32'h0000_00C3);

      // READ with no data: EOF after 16 RX cycles
      apply_stimulus(2'd2, 8'd1, 32'h0);
      repeat (TMO - 1) tick();
      check_output("eof_still_waiting", 32'(o_rx_ready), 32'd1);
      check_output("eof_no_rsp_yet", 32'(o_rsp_valid), 32'd0);
      tick();
      check_output("eof_rsp_valid", 32'(o_rsp_valid), 32'd1);
      take_rsp("eof", 32'hFFFF_FFFF);

      // Data on the last RX cycle beats the timeout
      apply_stimulus(2'd2, 8'd1, 32'h0);
      repeat (TMO - 1) tick();
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h77;
      tick();
      i_rx_valid = 1'b0;
      take_rsp("late_byte", 32'h0000_0077);

      // Illegal code: response 0 at N+1, sticky error, service continues
      apply_stimulus(2'd3, 8'd0, 32'h0);
      check_output("illegal_rsp_valid", 32'(o_rsp_valid), 32'd1);
      check_output("illegal_error", 32'(o_error), 32'd1);
      take_rsp("illegal", 32'h0);
      i_tx_ready = 1'b1;
      apply_stimulus(2'd1, 8'd0, 32'h0A);
      check_output("post_err_tx_data", 32'(o_tx_data), 32'h0A);
      tick();
      i_tx_ready = 1'b0;
      take_rsp("write0A", 32'h0);
      check_output("error_sticky", 32'(o_error), 32'd1);

      // EXIT 7: latched, no response, further requests refused
      apply_stimulus(2'd0, 8'd0, 32'd7);
      check_output("exit_flag", 32'(o_exit), 32'd1);
      check_output("exit_code_val", o_exit_code, 32'd7);
      check_output("exit_no_rsp", 32'(o_rsp_valid), 32'd0);
      i_req_valid  = 1'b1;
      i_req_call   = 2'd1;
      i_req_data   = 32'h33;
      i_tx_ready   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check_output("halt_req_ready", 32'(o_req_ready), 32'd0);
         check_output("halt_tx_valid", 32'(o_tx_valid), 32'd0);
         check_output("halt_rsp_valid", 32'(o_rsp_valid), 32'd0);
         tick();
      end
      i_req_valid = 1'b0;
      i_tx_ready  = 1'b0;
      check_output("halt_exit_kept", 32'(o_exit), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
